lvt_multiport_ram: RTL and testbench
====================================

// Module: lvt_multiport_ram
// PURPOSE
//  Multi-write, multi-read distributed RAM for the register file / ROB payload store.
//  Built from NUM_WR x NUM_RD 1W1R distributed banks plus a live-value table (LVT).
//  LVT records which write port last wrote each address; reads are combinational.
//  Post-reset sequencer zero-fills all entries before accepting writes.
// PARAMETERS
//  WIDTH   605  data bits per entry
//  DEPTH   16   entries; any value >=2, need not be a power of 2
//  NUM_WR  2    write ports, >=1
//  NUM_RD  4    read ports, >=1
// PORTS
//  clk        in   1                  clock; all state updates on posedge
//  rst_n      in   1                  asynchronous, active-low reset
//  we         in   NUM_WR             per-port write enable
//  waddr      in   NUM_WR x AW        write addresses, AW = $clog2(DEPTH)
//  wdata      in   NUM_WR x WIDTH     write data
//  raddr      in   NUM_RD x AW        read addresses
//  rdata      out  NUM_RD x WIDTH     read data, combinational from raddr
//  init_busy  out  1                  1 while the zero-fill sequencer runs
// BEHAVIOUR
//  - Reset (rst_n=0): FSM->INIT, init counter=0, LVT entries=0, init_busy=1.
//    Bank contents are not reset.
//  - INIT: each cycle writes 0 to addr=counter in every bank, sets LVT[counter]=0.
//    - Counter==DEPTH-1: go to READY next edge. init_busy=0 after exactly DEPTH edges.
//    - All we ignored. rdata forced to 0.
//  - A reset asserted mid-INIT or in READY restarts INIT from address 0.
//  - READY, write port w with we[w]=1 and waddr<DEPTH:
//    - Writes wdata[w] to banks[w][0..NUM_RD-1] at waddr.
//    - Sets LVT[waddr]=w.
//  - waddr>=DEPTH: write dropped, no state change.
//  - Same-address, same-cycle writes on several ports: highest port index wins in
//    LVT and hence in reads. Losing banks are still written, but are never visible.
//  - Read port r: rdata[r] = banks[LVT[raddr[r]]][r][raddr[r]].
//    - Zero-cycle latency.
//    - raddr>=DEPTH returns 0.
//  - Read-during-write to the same address returns the OLD value in that cycle;
//    the new value is visible from the cycle after the edge (feature off).
//  - NUM_WR==1: LVT is omitted and reads come from bank 0.
// CONFIGURATION
//  Macro LVT_RAM_WR_BYPASS_EN:
//  - Defined: in READY, if any we[w] hits raddr[r] in the same cycle, rdata[r] =
//    wdata of the highest such w (write-first, combinational forward).
//  - Undefined: no forwarding; read-old behaviour as above.
//  Init zero-fill and rdata=0 during INIT apply in both builds.
// STRUCTURE
//  - Package lvt_ram_pkg holds:
//    - typedef enum logic {INIT, READY} lvt_state_e
//    - function lvt_idx_w(n) = (n>1) ? $clog2(n) : 1
//  - Sub-module dram_1w1r (WIDTH, DEPTH):
//    - ram_style="distributed" array, sync write, async read.
//    - Instantiated NUM_WR*NUM_RD times via generate.
//    - In INIT its write port is muxed to counter/zero.
//  - LVT is flops with async reset, not distributed RAM.
// TESTING
//  1. Reset then hold: init_busy=1 for 16 cycles, 0 on the 17th; all raddr read 0.
//  2. we[0]=1, waddr=3, data=0xA5 -> the next cycle, all 4 read ports on addr 3
//     read 0xA5; other addresses read 0.
//  3. Same cycle: port0 writes addr 5 <- 0x11 and port1 writes addr 5 <- 0x22
//     -> reads of addr 5 = 0x22. Then port0 writes 0x33 -> reads = 0x33.
//  4. Write addr 7 <- 0x44 while reading addr 7 in the same cycle:
//     - Bypass off: rdata=old value, then 0x44 the next cycle.
//     - Bypass on: 0x44 in the same cycle.
//  5. Pulse rst_n low at init cycle 8: counter restarts, init_busy lasts 16 more
//     cycles; writes issued during INIT are not visible afterwards.
//  6. Random 10k-cycle traffic on all ports vs a behavioural reference model:
//     rdata must match on every cycle.

Source files
------------

// File: rtl/lvt_ram_pkg.sv
// Shared types and helpers for the live-value-table multiport RAM.
package lvt_ram_pkg;

    typedef enum logic {INIT, READY} lvt_state_e;

    // Width of an index into n items; never zero, so a single-item table still has a bit.
    function automatic int lvt_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_1w1r.sv
// One write, one read distributed RAM bank: synchronous write, asynchronous read.
module dram_1w1r #(
    parameter int WIDTH = 605,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH_V)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Addresses past the last entry exist when DEPTH is not a power of two.
    assign rdata = ({1'b0, raddr} < DEPTH_V) ? mem_q[raddr] : '0;

endmodule

// File: rtl/lvt_multiport_ram.sv
// Multi-write/multi-read RAM from NUM_WR x NUM_RD 1W1R banks plus a live-value table.
// Optional macro LVT_RAM_WR_BYPASS_EN forwards same-cycle write data to matching reads.
module lvt_multiport_ram
    import lvt_ram_pkg::*;
#(
    parameter int WIDTH  = 605,
    parameter int DEPTH  = 16,
    parameter int NUM_WR = 2,
    parameter int NUM_RD = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WR-1:0]       we,
    input  logic [NUM_WR*AW-1:0]    waddr,
    input  logic [NUM_WR*WIDTH-1:0] wdata,
    input  logic [NUM_RD*AW-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0] rdata,
    output logic                    init_busy
);

    localparam int          LW      = lvt_idx_w(NUM_WR);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    lvt_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready;

    logic [AW-1:0]    wa      [NUM_WR];
    logic [WIDTH-1:0] wd      [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;
    logic [AW-1:0]    ra      [NUM_RD];
    logic [NUM_RD-1:0] ra_ok;
    logic [LW-1:0]    lvt_rd  [NUM_RD];
    logic [WIDTH-1:0] rd_a    [NUM_RD];

    logic [NUM_WR-1:0] bank_we;
    logic [AW-1:0]    bank_wa [NUM_WR];
    logic [WIDTH-1:0] bank_wd [NUM_WR];
    logic [WIDTH-1:0] bank_rd [NUM_WR][NUM_RD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = READY;
                cnt_d   = '0;
            end
        end
    end

    assign ready     = (state_q == READY);
    assign init_busy = ~ready;

    // During INIT every bank write port is stolen by the zero-fill sequencer.
    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        assign wa[w]      = waddr[w*AW +: AW];
        assign wd[w]      = wdata[w*WIDTH +: WIDTH];
        assign wr_ok[w]   = ready && we[w] && ({1'b0, wa[w]} < DEPTH_V);
        assign bank_we[w] = ready ? wr_ok[w] : 1'b1;
        assign bank_wa[w] = ready ? wa[w] : cnt_q;
        assign bank_wd[w] = ready ? wd[w] : '0;

        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            dram_1w1r #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[w]),
                .waddr (bank_wa[w]),
                .wdata (bank_wd[w]),
                .raddr (ra[r]),
                .rdata (bank_rd[w][r])
            );
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rport
        assign ra[r]    = raddr[r*AW +: AW];
        assign ra_ok[r] = ({1'b0, ra[r]} < DEPTH_V);
        assign rdata[r*WIDTH +: WIDTH] = rd_a[r];
    end

    if (NUM_WR > 1) begin : g_lvt
        logic [LW-1:0] lvt_q [DEPTH];
        logic [LW-1:0] lvt_d [DEPTH];

        // Later (higher-index) ports overwrite earlier ones, so the highest port wins.
        always_comb begin
            lvt_d = lvt_q;
            if (!ready) begin
                lvt_d[cnt_q] = '0;
            end else begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok[w]) begin
                        lvt_d[wa[w]] = LW'(w);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int a = 0; a < DEPTH; a++) begin
                    lvt_q[a] <= '0;
                end
            end else begin
                lvt_q <= lvt_d;
            end
        end

        always_comb begin
            for (int r = 0; r < NUM_RD; r++) begin
                lvt_rd[r] = ra_ok[r] ? lvt_q[ra[r]] : '0;
            end
        end
    end else begin : g_no_lvt
        always_comb begin
            for (int r = 0; r < NUM_RD; r++) begin
                lvt_rd[r] = '0;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_a[r] = '0;
            if (ready && ra_ok[r]) begin
                rd_a[r] = bank_rd[lvt_rd[r]][r];
`ifdef LVT_RAM_WR_BYPASS_EN
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok[w] && (wa[w] == ra[r])) begin
                        rd_a[r] = wd[w];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Bench for lvt_multiport_ram: directed literal cases plus random traffic vs a memory model.
module tb_lvt_multiport_ram;

    localparam int W   = 605;
    localparam int D   = 16;
    localparam int NW  = 2;
    localparam int NR  = 4;
    localparam int AW  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  waddr;
    logic [NW*W-1:0]   wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*W-1:0]   rdata;
    logic              init_busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model [D];
    int           init_left;

    lvt_multiport_ram #(
        .WIDTH  (W),
        .DEPTH  (D),
        .NUM_WR (NW),
        .NUM_RD (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: after reset, DEPTH edges of zero-fill; afterwards writes land, highest port last.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_left <= D;
            for (int a = 0; a < D; a++) model[a] <= '0;
        end else if (init_left > 0) begin
            init_left <= init_left - 1;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (we[w] && (int'(waddr[w*AW +: AW]) < D))
                    model[waddr[w*AW +: AW]] <= wdata[w*W +: W];
            end
        end
    end

    function automatic logic [W-1:0] expect_rd(input int r);
        logic [W-1:0] e;
        int a;
        a = int'(raddr[r*AW +: AW]);
        if (init_left > 0 || a >= D) return '0;
        e = model[a];
`ifdef LVT_RAM_WR_BYPASS_EN
        for (int w = 0; w < NW; w++)
            if (we[w] && int'(waddr[w*AW +: AW]) == a) e = wdata[w*W +: W];
`endif
        return e;
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("init_busy", {{(W-1){1'b0}}, init_busy}, {{(W-1){1'b0}}, (init_left > 0)});
        for (int r = 0; r < NR; r++)
            chk($sformatf("rdata%0d", r), rdata[r*W +: W], expect_rd(r));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_raddr(input logic [AW-1:0] a);
        for (int r = 0; r < NR; r++) raddr[r*AW +: AW] = a;
    endtask

    task automatic chk_all(input string name, input logic [W-1:0] exp);
        for (int r = 0; r < NR; r++)
            chk($sformatf("%s_p%0d", name, r), rdata[r*W +: W], exp);
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (init_busy && n < 100) begin
            step();
            n++;
        end
        chk(name, W'(n), W'(16));
    endtask

    initial begin
        logic [607:0] tmp;
        rst_n = 1'b0;
        we    = '0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        repeat (3) step();
        chk("reset_busy", W'(init_busy), W'(1));
        chk_all("reset_rd", '0);
        rst_n = 1'b1;

        // 1: init lasts exactly 16 edges, reads 0 throughout
        count_init("init_len");
        chk_all("post_init", '0);

        // 2: single write visible next cycle
        we = 2'b01; waddr[0 +: AW] = 4'd3; wdata[0 +: W] = W'(32'hA5);
        set_all_raddr(4'd3);
        step();
        we = '0;
        #1 chk_all("wr_a5", W'(32'hA5));
        raddr[AW +: AW] = 4'd4;
        #1 chk("other_addr", rdata[W +: W], '0);

        // 3: same-address collision, highest port wins
        we = 2'b11; waddr = {4'd5, 4'd5};
        wdata = {W'(32'h22), W'(32'h11)};
        set_all_raddr(4'd5);
        step();
        we = '0;
        #1 chk_all("collide", W'(32'h22));
        we = 2'b01; wdata[0 +: W] = W'(32'h33);
        step();
        we = '0;
        #1 chk_all("rewrite", W'(32'h33));

        // 4: read-during-write
        we = 2'b01; waddr[0 +: AW] = 4'd7; wdata[0 +: W] = W'(32'h55);
        step();
        wdata[0 +: W] = W'(32'h44);
        set_all_raddr(4'd7);
        #1;
`ifdef LVT_RAM_WR_BYPASS_EN
        chk_all("rdw_same", W'(32'h44));
`else
        chk_all("rdw_same", W'(32'h55));
`endif
        step();
        we = '0;
        #1 chk_all("rdw_next", W'(32'h44));

        // 5: reset pulse mid-init restarts the fill; INIT writes are dropped
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (8) step();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        we = 2'b11; waddr = {4'd3, 4'd3};
        wdata = {W'(32'hFF), W'(32'hEE)};
        count_init("reinit_len");
        we = '0;
        set_all_raddr(4'd3);
        #1 chk_all("init_wr_dropped", '0);
        raddr[0 +: AW] = 4'd7;
        #1 chk("cleared7", rdata[0 +: W], '0);

        // 6: random traffic, checked every cycle by the compare process
        for (int c = 0; c < 10000; c++) begin
            for (int w = 0; w < NW; w++) begin
                for (int k = 0; k < 19; k++) tmp[k*32 +: 32] = $urandom;
                wdata[w*W +: W] = tmp[W-1:0];
                waddr[w*AW +: AW] = AW'($urandom_range(0, D-1));
                we[w] = ($urandom_range(0, 2) != 0);
            end
            for (int r = 0; r < NR; r++) raddr[r*AW +: AW] = AW'($urandom_range(0, D-1));
            if (c == 5000) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step();
        end
        we = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
